// File: rtl/ep_arith_engine.sv
// rtl/ep_arith_engine.sv - FrontPanel operand/mode arithmetic engine (ADD/SUB/ACC/shift-add MUL)
//
// Ports:
//   ti_clk    in   host interface clock, rising edge
//   ti_rst_n  in   asynchronous active-low reset
//   start     in   one-cycle request pulse (TriggerIn)
//   clr       in   one-cycle synchronous clear of acc/result/status/count
//   mode      in   0=ADD 1=SUB 2=ACC 3=MUL, sampled with start
//   op_a      in   operand A, sampled with start
//   op_b      in   operand B, sampled with start
//   result    out  registered 2*WIDTH result
//   busy      out  high while a MUL is iterating
//   done      out  one-cycle pulse when result updates
//   overflow  out  sticky carry/borrow/accumulator-wrap flag
//   op_count  out  completed operation counter (wraps)
//   led       out  active-low LED drive from result low bits
//
// Optional feature: define ARITH_SAT_EN to make ACC saturate at all-ones
// instead of wrapping.
module ep_arith_engine #(
  parameter int WIDTH = 16,
  parameter int LED_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 ti_clk,
  input  logic                 ti_rst_n,
  input  logic                 start,
  input  logic                 clr,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [CNT_W-1:0]     op_count,
  output logic [LED_W-1:0]     led
);

  localparam int RW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] M_ADD = 2'd0;
  localparam logic [1:0] M_SUB = 2'd1;
  localparam logic [1:0] M_ACC = 2'd2;
  localparam logic [1:0] M_MUL = 2'd3;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    result_q, result_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [RW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_add;
  logic [RW:0]      acc_sum;
  logic [RW-1:0]    mul_step;
  logic             mul_last;

  assign sum_add  = {1'b0, op_a} + {1'b0, op_b};
  assign acc_sum  = {1'b0, acc_q} + {{(WIDTH + 1){1'b0}}, op_a};
  assign mul_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last = (iter_q == IW'(WIDTH - 1));

  // State register (plus all datapath flops)
  always_ff @(posedge ti_clk or negedge ti_rst_n) begin
    if (!ti_rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; clr aborts any MUL and swallows a coincident start
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && mode == M_MUL) state_d = S_MUL;
        S_MUL:   if (mul_last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    result_d = result_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;

    if (clr) begin
      result_d = '0;
      acc_d    = '0;
      ovf_d    = 1'b0;
      cnt_d    = '0;
    end else begin
      if (state_q == S_IDLE && start) begin
        case (mode)
          M_ADD: begin
            result_d = {{(WIDTH - 1){1'b0}}, sum_add};
            ovf_d    = ovf_q | sum_add[WIDTH];
            done_d   = 1'b1;
          end
          M_SUB: begin
            result_d = {{WIDTH{1'b0}}, op_a - op_b};
            ovf_d    = ovf_q | (op_a < op_b);
            done_d   = 1'b1;
          end
          M_ACC: begin
`ifdef ARITH_SAT_EN
            acc_d = acc_sum[RW] ? '1 : acc_sum[RW-1:0];
`else
            acc_d = acc_sum[RW-1:0];
`endif
            result_d = acc_d;
            ovf_d    = ovf_q | acc_sum[RW];
            done_d   = 1'b1;
          end
          default: begin
            // Multiplicand shifts left and multiplier right each iteration
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            prod_d   = '0;
            iter_d   = '0;
          end
        endcase
      end else if (state_q == S_MUL) begin
        prod_d   = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        iter_d   = iter_q + IW'(1);
        if (mul_last) begin
          result_d = mul_step;
          done_d   = 1'b1;
        end
      end
      if (done_d) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q == S_MUL);
    result   = result_q;
    done     = done_q;
    overflow = ovf_q;
    op_count = cnt_q;
    led      = ~result_q[LED_W-1:0];
  end

endmodule

// File: tb/tb_ep_arith_engine.sv
// tb/tb_ep_arith_engine.sv - scoreboard bench for ep_arith_engine
module tb_ep_arith_engine;

  localparam int W = 16;

  logic        clk;
  logic        rst_n;
  logic        start, clr;
  logic [1:0]  mode;
  logic [15:0] op_a, op_b;
  logic [31:0] result;
  logic        busy, done, overflow;
  logic [15:0] op_count;
  logic [3:0]  led;

  // Narrow instance used to reach accumulator saturation/wrap quickly
  logic        s_start, s_clr;
  logic [1:0]  s_mode;
  logic [3:0]  s_a, s_b;
  logic [7:0]  s_result;
  logic        s_busy, s_done, s_ovf;
  logic [7:0]  s_cnt;
  logic [3:0]  s_led;

  ep_arith_engine #(.WIDTH(16), .LED_W(4), .CNT_W(16)) dut (
    .ti_clk(clk), .ti_rst_n(rst_n), .start(start), .clr(clr), .mode(mode),
    .op_a(op_a), .op_b(op_b), .result(result), .busy(busy), .done(done),
    .overflow(overflow), .op_count(op_count), .led(led)
  );

  ep_arith_engine #(.WIDTH(4), .LED_W(4), .CNT_W(8)) dut_s (
    .ti_clk(clk), .ti_rst_n(rst_n), .start(s_start), .clr(s_clr), .mode(s_mode),
    .op_a(s_a), .op_b(s_b), .result(s_result), .busy(s_busy), .done(s_done),
    .overflow(s_ovf), .op_count(s_cnt), .led(s_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          done_seen = 0;
  int          pushed = 0;

  logic [31:0] m_acc;
  logic        m_ovf;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] r);
    exp_t e;
    m_cnt  = m_cnt + 16'd1;
    e.res  = r;
    e.ovf  = m_ovf;
    e.cnt  = m_cnt;
    sb.push_back(e);
    pushed++;
  endtask

  // Drive one start pulse and record what the DUT should report at done
  task automatic op(input logic [1:0] md, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [32:0] acs;
    start = 1'b1; mode = md; op_a = a; op_b = b;
    case (md)
      2'd0: begin s = {1'b0, a} + {1'b0, b}; m_ovf = m_ovf | s[16]; push({15'd0, s}); end
      2'd1: begin m_ovf = m_ovf | (a < b); push({16'd0, 16'(a - b)}); end
      2'd2: begin
        acs = {1'b0, m_acc} + {17'd0, a};
        m_acc = acs[31:0];
        m_ovf = m_ovf | acs[32];
        push(m_acc);
      end
      default: push(32'(a) * 32'(b));
    endcase
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic model_clear();
    m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      chk("sb_expected_done", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_result", 64'(result), 64'(mon_e.res));
        chk("sb_overflow", 64'(overflow), 64'(mon_e.ovf));
        chk("sb_op_count", 64'(op_count), 64'(mon_e.cnt));
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; mode = '0; op_a = '0; op_b = '0;
    s_start = 1'b0; s_clr = 1'b0; s_mode = '0; s_a = '0; s_b = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_op_count", 64'(op_count), 64'(0));
    chk("rst_led", 64'(led), 64'(4'hF));
    rst_n = 1'b1;
    @(negedge clk);

    // ADD 3+4
    op(2'd0, 16'h0003, 16'h0004);
    chk("add_done", 64'(done), 64'(1));
    chk("add_led", 64'(led), 64'(4'b1000));
    @(negedge clk);
    chk("add_done_pulse", 64'(done), 64'(0));

    // Carry, then borrow with sticky overflow
    op(2'd0, 16'hFFFF, 16'h0001);
    @(negedge clk);
    op(2'd1, 16'h0005, 16'h0007);
    @(negedge clk);
    chk("sub_ovf_sticky", 64'(overflow), 64'(1));

    // MUL with an ignored start at cycle 5
    op(2'd3, 16'h1234, 16'h0100);
    chk("mul_busy_t0", 64'(busy), 64'(1));
    for (int k = 1; k <= W; k++) begin
      if (k == 5) begin
        start = 1'b1; mode = 2'd0; op_a = 16'h0001; op_b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (k < W) begin
        chk("mul_busy", 64'(busy), 64'(1));
        chk("mul_no_early_done", 64'(done), 64'(0));
      end else begin
        chk("mul_busy_end", 64'(busy), 64'(0));
        chk("mul_done_at_w", 64'(done), 64'(1));
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("mul_op_count", 64'(op_count), 64'(4));

    // Back-to-back ACCs
    op(2'd2, 16'hFFFF, 16'h0000);
    op(2'd2, 16'hFFFF, 16'h0000);
    op(2'd2, 16'hFFFF, 16'h0000);
    @(negedge clk);
    chk("acc_final", 64'(result), 64'(32'h0002FFFD));

    // Clear
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    chk("clr_result", 64'(result), 64'(0));
    chk("clr_op_count", 64'(op_count), 64'(0));
    chk("clr_overflow", 64'(overflow), 64'(0));

    // MUL aborted by clr at cycle 8
    start = 1'b1; mode = 2'd3; op_a = 16'h0003; op_b = 16'h0005;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy_t0", 64'(busy), 64'(1));
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    repeat (W + 4) @(negedge clk);
    chk("abort_no_count", 64'(op_count), 64'(0));

    // clr and start together
    clr = 1'b1; start = 1'b1; mode = 2'd3; op_a = 16'h0007; op_b = 16'h0007;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_start_busy", 64'(busy), 64'(0));
    clr = 1'b1; start = 1'b1; mode = 2'd0; op_a = 16'h0009; op_b = 16'h0001;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("clr_start_done", 64'(done), 64'(0));
    repeat (W + 2) @(negedge clk);
    chk("clr_start_count", 64'(op_count), 64'(0));
    chk("clr_start_result", 64'(result), 64'(0));

    // ACC unaffected by ADD/SUB/MUL: acc restarts from the cleared value
    op(2'd0, 16'h0010, 16'h0020);
    op(2'd2, 16'h0100, 16'h0000);
    @(negedge clk);
    chk("acc_independent", 64'(result), 64'(32'h00000100));

    // Async reset in the middle of a MUL
    start = 1'b1; mode = 2'd3; op_a = 16'hFFFF; op_b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_op_count", 64'(op_count), 64'(0));
    chk("arst_led", 64'(led), 64'(4'hF));
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(2'd0, 16'h0001, 16'h0002);
    repeat (W + 4) @(negedge clk);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("done_total", 64'(done_seen), 64'(pushed));

    // Accumulator wrap/saturation on the narrow instance: 17*0xF = 0xFF
    s_mode = 2'd2; s_a = 4'hF; s_b = 4'h0; s_start = 1'b1;
    repeat (17) @(negedge clk);
    chk("s_acc_max", 64'(s_result), 64'(8'hFF));
    chk("s_acc_max_ovf", 64'(s_ovf), 64'(0));
    @(negedge clk);
`ifdef ARITH_SAT_EN
    chk("s_acc_sat1", 64'(s_result), 64'(8'hFF));
`else
    chk("s_acc_wrap1", 64'(s_result), 64'(8'h0E));
`endif
    chk("s_acc_ovf", 64'(s_ovf), 64'(1));
    @(negedge clk);
    s_start = 1'b0;
`ifdef ARITH_SAT_EN
    chk("s_acc_sat2", 64'(s_result), 64'(8'hFF));
`else
    chk("s_acc_wrap2", 64'(s_result), 64'(8'h1D));
`endif
    chk("s_op_count", 64'(s_cnt), 64'(19));
    @(negedge clk);
    chk("s_done_clear", 64'(s_done), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
